// File: rtl/jtmx5k_snd_pkg.sv
// Shared widths, gain codes and saturation limits for the jtmx5k sound output stage.
package jtmx5k_snd_pkg;

    localparam logic [1:0] GAIN_HALF = 2'd0;
    localparam logic [1:0] GAIN_ONE  = 2'd1;
    localparam logic [1:0] GAIN_ONE5 = 2'd2;
    localparam logic [1:0] GAIN_TWO  = 2'd3;

    localparam int SUM_W  = 17;
    localparam int GAIN_W = 19;
    localparam int DC_W   = 20;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // Exact gain on the mono sum; right shifts floor toward minus infinity.
    function automatic logic signed [GAIN_W-1:0] apply_gain(
        input logic signed [SUM_W-1:0] sum,
        input logic [1:0]              code
    );
        logic signed [GAIN_W-1:0] s;
        s = {{(GAIN_W-SUM_W){sum[SUM_W-1]}}, sum};
        case (code)
            GAIN_HALF: apply_gain = s >>> 1;
            GAIN_ONE:  apply_gain = s;
            GAIN_ONE5: apply_gain = (s + (s <<< 1)) >>> 1;
            default:   apply_gain = s <<< 1;
        endcase
    endfunction

endpackage

// File: rtl/jtmx5k_snd_mix_if.sv
// Sample-in / mono-out bundle between the sound CPU block and the mixer.
interface jtmx5k_snd_mix_if;

    logic               sample_in;
    logic signed [15:0] snd_left;
    logic signed [15:0] snd_right;
    logic [1:0]         fxlevel;
    logic               mute;
    logic signed [15:0] snd;
    logic               sample;
    logic               peak;

    modport master (
        output sample_in, snd_left, snd_right, fxlevel, mute,
        input  snd, sample, peak
    );

    modport slave (
        input  sample_in, snd_left, snd_right, fxlevel, mute,
        output snd, sample, peak
    );

endinterface

// File: rtl/jtmx5k_peak_hold.sv
// Clip indicator: any clip reloads a hold counter, peak stays lit while it is non-zero.
module jtmx5k_peak_hold #(
    parameter logic [23:0] PEAK_HOLD = 24'd12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clip,
    output logic peak
);

    logic [23:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clip) begin
            cnt <= PEAK_HOLD;
        end else if (cnt != '0) begin
            cnt <= cnt - 24'd1;
        end
    end

    assign peak = (cnt != '0);

endmodule

// File: rtl/jtmx5k_snd_mix.sv
// Stereo-to-mono mixer: edge capture, gain, DC blocker, 16-bit saturation and peak LED.
module jtmx5k_snd_mix
    import jtmx5k_snd_pkg::*;
#(
    parameter logic [23:0] PEAK_HOLD = 24'd12_000_000,
    parameter int          DC_SHIFT  = 8,
    parameter bit          DC_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    jtmx5k_snd_mix_if.slave    bus
);

    localparam logic signed [DC_W-1:0] Y_MAX = {{(DC_W-16){SAT_MAX[15]}}, SAT_MAX};
    localparam logic signed [DC_W-1:0] Y_MIN = {{(DC_W-16){SAT_MIN[15]}}, SAT_MIN};

    logic                     sample_in_d;
    logic                     v0, v1, v2, v3;
    logic signed [SUM_W-1:0]  sum;
    logic signed [GAIN_W-1:0] gained;
    logic signed [DC_W-1:0]   x, x_prev, y, y_n;
    logic signed [15:0]       sat;
    logic                     clip;

    assign v0 = bus.sample_in & ~sample_in_d;

    always_comb begin
        x = {{(DC_W-GAIN_W){gained[GAIN_W-1]}}, gained};
        if (DC_EN) begin
            y_n = x - x_prev + y - (y >>> DC_SHIFT);
        end else begin
            y_n = x;
        end
    end

    always_comb begin
        clip = 1'b0;
        sat  = y[15:0];
        if (y > Y_MAX) begin
            sat  = SAT_MAX;
            clip = 1'b1;
        end else if (y < Y_MIN) begin
            sat  = SAT_MIN;
            clip = 1'b1;
        end
    end

    // y is both the DC-blocker state and the S3 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_in_d <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            sum         <= '0;
            gained      <= '0;
            x_prev      <= '0;
            y           <= '0;
            bus.snd     <= '0;
            bus.sample  <= 1'b0;
        end else begin
            sample_in_d <= bus.sample_in;
            v1          <= v0;
            v2          <= v1;
            v3          <= v2;
            bus.sample  <= v3;
            if (v0) begin
                sum <= {bus.snd_left[15], bus.snd_left} + {bus.snd_right[15], bus.snd_right};
            end
            if (v1) begin
                gained <= apply_gain(sum, bus.fxlevel);
            end
            if (v2) begin
                x_prev <= x;
                y      <= y_n;
            end
            if (v3) begin
                bus.snd <= bus.mute ? '0 : sat;
            end
        end
    end

    jtmx5k_peak_hold #(
        .PEAK_HOLD (PEAK_HOLD)
    ) u_peak (
        .clk  (clk),
        .rst  (rst),
        .clip (v3 & clip),
        .peak (bus.peak)
    );

endmodule
